// File: rtl/board_turn_controller.sv
// Tic-tac-toe board/turn sequencer: takes move requests, drives X_en/O_en into the
// move checker, commits legal moves and detects win/draw. Define WIN_SCORE_EN to add win counters.
//
// state | meaning
// WAIT  | idle, accepting a move request
// CHECK | enable asserted, checker result sampled at end of cycle
// EVAL  | scan lines of the player who just moved
// OVER  | game finished, only new_game/reset leave
module board_turn_controller #(
  parameter logic FIRST_PLAYER = 1'b0
`ifdef WIN_SCORE_EN
  , parameter int SCORE_W = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  input  logic       illegal_move,
  output logic       move_ready,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [8:0] X_en,
  output logic [8:0] O_en,
  output logic       turn,
  output logic       illegal_flag,
  output logic [3:0] move_count,
  output logic       game_over,
  output logic [1:0] winner
`ifdef WIN_SCORE_EN
  , output logic [SCORE_W-1:0] x_score
  , output logic [SCORE_W-1:0] o_score
`endif
);

  typedef enum logic [1:0] {WAIT, CHECK, EVAL, OVER} state_t;

  state_t          state;
  logic [8:0][1:0] board;
  logic [3:0]      sel;
  logic            line_done;

  function automatic logic has_line(input logic [8:0][1:0] b, input logic [1:0] c);
    has_line = (b[0] == c && b[1] == c && b[2] == c) ||
               (b[3] == c && b[4] == c && b[5] == c) ||
               (b[6] == c && b[7] == c && b[8] == c) ||
               (b[0] == c && b[3] == c && b[6] == c) ||
               (b[1] == c && b[4] == c && b[7] == c) ||
               (b[2] == c && b[5] == c && b[8] == c) ||
               (b[0] == c && b[4] == c && b[8] == c) ||
               (b[2] == c && b[4] == c && b[6] == c);
  endfunction

  // turn has already toggled by EVAL, so the mover is the opposite player
  assign line_done = has_line(board, turn ? 2'b01 : 2'b10);

  assign pos1 = board[0];
  assign pos2 = board[1];
  assign pos3 = board[2];
  assign pos4 = board[3];
  assign pos5 = board[4];
  assign pos6 = board[5];
  assign pos7 = board[6];
  assign pos8 = board[7];
  assign pos9 = board[8];

  always_ff @(posedge clk) begin
    if (!rst_n || new_game) begin
      state        <= WAIT;
      board        <= '0;
      sel          <= '0;
      X_en         <= '0;
      O_en         <= '0;
      turn         <= FIRST_PLAYER;
      illegal_flag <= 1'b0;
      move_count   <= '0;
      game_over    <= 1'b0;
      winner       <= 2'b00;
      move_ready   <= 1'b1;
    end else begin
      illegal_flag <= 1'b0;
      case (state)
        WAIT: begin
          if (move_valid) begin
            if (move_pos <= 4'd8) begin
              sel        <= move_pos;
              move_ready <= 1'b0;
              state      <= CHECK;
              if (turn) O_en <= 9'd1 << move_pos;
              else      X_en <= 9'd1 << move_pos;
            end else begin
              illegal_flag <= 1'b1;
            end
          end
        end
        CHECK: begin
          X_en <= '0;
          O_en <= '0;
          if (illegal_move) begin
            illegal_flag <= 1'b1;
            move_ready   <= 1'b1;
            state        <= WAIT;
          end else begin
            board[sel] <= turn ? 2'b10 : 2'b01;
            turn       <= ~turn;
            move_count <= (move_count == 4'd9) ? move_count : move_count + 4'd1;
            state      <= EVAL;
          end
        end
        EVAL: begin
          if (line_done) begin
            winner    <= turn ? 2'b01 : 2'b10;
            game_over <= 1'b1;
            state     <= OVER;
          end else if (move_count == 4'd9) begin
            winner    <= 2'b11;
            game_over <= 1'b1;
            state     <= OVER;
          end else begin
            move_ready <= 1'b1;
            state      <= WAIT;
          end
        end
        OVER: state <= OVER;
        default: state <= WAIT;
      endcase
    end
  end

`ifdef WIN_SCORE_EN
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // counters survive new_game; only reset clears them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_score <= '0;
      o_score <= '0;
    end else if (!new_game && state == EVAL && line_done) begin
      if (turn) begin
        if (x_score != SCORE_MAX) x_score <= x_score + 1'b1;
      end else begin
        if (o_score != SCORE_MAX) o_score <= o_score + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_board_turn_controller.sv
// Directed bench for board_turn_controller; the checker is modelled by a bench-side occupancy mask.
module tb_board_turn_controller;
  logic       clk = 1'b0;
  logic       rst_n, new_game, move_valid, illegal_move;
  logic [3:0] move_pos;
  logic       move_ready, turn, illegal_flag, game_over;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, winner;
  logic [8:0] X_en, O_en;
  logic [3:0] move_count;
`ifdef WIN_SCORE_EN
  logic [3:0] x_score, o_score;
`endif
  logic [17:0] board_v;
  logic [8:0]  occ;
  int n_vec = 0;
  int n_err = 0;

  board_turn_controller dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid),
    .move_pos(move_pos), .illegal_move(illegal_move), .move_ready(move_ready),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
    .X_en(X_en), .O_en(O_en), .turn(turn), .illegal_flag(illegal_flag),
    .move_count(move_count), .game_over(game_over), .winner(winner)
`ifdef WIN_SCORE_EN
    , .x_score(x_score), .o_score(o_score)
`endif
  );

  always #5 clk = ~clk;

  assign board_v = {pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};
  assign illegal_move = |((X_en | O_en) & occ);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_move(input logic [3:0] p);
    move_valid = 1'b1; move_pos = p;
    step();
    move_valid = 1'b0;
    step();
    occ[p] = 1'b1;
    step();
  endtask

  task automatic clear_game();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    occ = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; new_game = 1'b0; move_valid = 1'b1; move_pos = 4'd3; occ = '0;
    step(); step();
    move_valid = 1'b0; rst_n = 1'b1;
    n_vec++; if (board_v !== 18'h0) begin n_err++; $display("FAIL rst_board: got %h want %h", board_v, 18'h0); end
    n_vec++; if ((X_en | O_en) !== 9'h0) begin n_err++; $display("FAIL rst_en: got %h want %h", X_en | O_en, 9'h0); end
    n_vec++; if (turn !== 1'b0) begin n_err++; $display("FAIL rst_turn: got %b want 0", turn); end
    n_vec++; if ({move_count, illegal_flag, game_over, winner} !== 8'h0) begin n_err++; $display("FAIL rst_status: got %h want 00", {move_count, illegal_flag, game_over, winner}); end
    n_vec++; if (move_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", move_ready); end
`ifdef WIN_SCORE_EN
    n_vec++; if ({x_score, o_score} !== 8'h0) begin n_err++; $display("FAIL rst_score: got %h want 00", {x_score, o_score}); end
`endif
  endtask

  task automatic test_x_move();
    move_valid = 1'b1; move_pos = 4'd4;
    step();
    move_valid = 1'b0;
    n_vec++; if (X_en !== 9'h010) begin n_err++; $display("FAIL x_en: got %h want %h", X_en, 9'h010); end
    n_vec++; if (O_en !== 9'h000) begin n_err++; $display("FAIL x_o_en: got %h want %h", O_en, 9'h000); end
    n_vec++; if (move_ready !== 1'b0) begin n_err++; $display("FAIL x_ready_check: got %b want 0", move_ready); end
    step();
    occ[4] = 1'b1;
    n_vec++; if (pos5 !== 2'b01) begin n_err++; $display("FAIL x_pos5: got %b want 01", pos5); end
    n_vec++; if (turn !== 1'b1) begin n_err++; $display("FAIL x_turn: got %b want 1", turn); end
    n_vec++; if (move_count !== 4'd1) begin n_err++; $display("FAIL x_count: got %0d want 1", move_count); end
    n_vec++; if ((X_en | O_en) !== 9'h0 || move_ready !== 1'b0) begin n_err++; $display("FAIL x_commit_ctl: got en %h ready %b want 0 0", X_en | O_en, move_ready); end
    step();
    n_vec++; if (move_ready !== 1'b1) begin n_err++; $display("FAIL x_ready_back: got %b want 1", move_ready); end
  endtask

  task automatic test_illegal_occupied();
    move_valid = 1'b1; move_pos = 4'd4;
    step();
    move_valid = 1'b0;
    n_vec++; if (O_en !== 9'h010) begin n_err++; $display("FAIL occ_o_en: got %h want %h", O_en, 9'h010); end
    step();
    n_vec++; if (illegal_flag !== 1'b1) begin n_err++; $display("FAIL occ_flag: got %b want 1", illegal_flag); end
    n_vec++; if ({pos5, turn, move_count} !== {2'b01, 1'b1, 4'd1}) begin n_err++; $display("FAIL occ_hold: got %h want %h", {pos5, turn, move_count}, {2'b01, 1'b1, 4'd1}); end
    n_vec++; if ((X_en | O_en) !== 9'h0 || move_ready !== 1'b1) begin n_err++; $display("FAIL occ_ctl: got en %h ready %b want 0 1", X_en | O_en, move_ready); end
    step();
    n_vec++; if (illegal_flag !== 1'b0) begin n_err++; $display("FAIL occ_pulse_len: got %b want 0", illegal_flag); end
  endtask

  task automatic test_bad_code();
    move_valid = 1'b1; move_pos = 4'd12;
    step();
    move_valid = 1'b0;
    n_vec++; if (illegal_flag !== 1'b1) begin n_err++; $display("FAIL code_flag: got %b want 1", illegal_flag); end
    n_vec++; if ((X_en | O_en) !== 9'h0) begin n_err++; $display("FAIL code_en: got %h want 0", X_en | O_en); end
    n_vec++; if ({move_ready, turn, move_count, board_v} !== {1'b1, 1'b1, 4'd1, 18'h00100}) begin n_err++; $display("FAIL code_state: got %h want %h", {move_ready, turn, move_count, board_v}, {1'b1, 1'b1, 4'd1, 18'h00100}); end
    step();
    n_vec++; if (illegal_flag !== 1'b0) begin n_err++; $display("FAIL code_pulse_len: got %b want 0", illegal_flag); end
  endtask

  task automatic test_win();
    clear_game();
    do_move(4'd0); do_move(4'd1); do_move(4'd4); do_move(4'd2); do_move(4'd8);
    n_vec++; if (winner !== 2'b01) begin n_err++; $display("FAIL win_winner: got %b want 01", winner); end
    n_vec++; if ({game_over, move_ready, move_count} !== {1'b1, 1'b0, 4'd5}) begin n_err++; $display("FAIL win_status: got %h want %h", {game_over, move_ready, move_count}, {1'b1, 1'b0, 4'd5}); end
    move_valid = 1'b1; move_pos = 4'd3;
    step(); step(); step();
    move_valid = 1'b0;
    n_vec++; if ({X_en, O_en, pos4, move_count, winner} !== {9'h0, 9'h0, 2'b00, 4'd5, 2'b01}) begin n_err++; $display("FAIL win_ignore: got %h want %h", {X_en, O_en, pos4, move_count, winner}, {9'h0, 9'h0, 2'b00, 4'd5, 2'b01}); end
`ifdef WIN_SCORE_EN
    n_vec++; if ({x_score, o_score} !== 8'h10) begin n_err++; $display("FAIL win_score: got %h want 10", {x_score, o_score}); end
`endif
  endtask

  task automatic test_draw();
    clear_game();
    do_move(4'd0); do_move(4'd1); do_move(4'd2); do_move(4'd4); do_move(4'd3);
    do_move(4'd5); do_move(4'd7); do_move(4'd6); do_move(4'd8);
    n_vec++; if (move_count !== 4'd9) begin n_err++; $display("FAIL draw_count: got %0d want 9", move_count); end
    n_vec++; if ({winner, game_over} !== 3'b111) begin n_err++; $display("FAIL draw_result: got %b want 111", {winner, game_over}); end
    n_vec++; if (board_v !== 18'b01_10_01_01_10_10_10_01_01) begin n_err++; $display("FAIL draw_board: got %h want %h", board_v, 18'b01_10_01_01_10_10_10_01_01); end
`ifdef WIN_SCORE_EN
    n_vec++; if ({x_score, o_score} !== 8'h10) begin n_err++; $display("FAIL draw_score: got %h want 10", {x_score, o_score}); end
`endif
  endtask

  task automatic test_new_game_mid_check();
    clear_game();
    do_move(4'd0);
    move_valid = 1'b1; move_pos = 4'd3;
    step();
    move_valid = 1'b0;
    n_vec++; if (O_en !== 9'h008) begin n_err++; $display("FAIL ng_o_en: got %h want %h", O_en, 9'h008); end
    new_game = 1'b1;
    step();
    new_game = 1'b0; occ = '0;
    n_vec++; if ({board_v, X_en, O_en} !== 36'h0) begin n_err++; $display("FAIL ng_clear: got %h want 0", {board_v, X_en, O_en}); end
    n_vec++; if ({turn, move_count, illegal_flag, game_over, winner, move_ready} !== 10'b0_0000_0_0_00_1) begin n_err++; $display("FAIL ng_status: got %b want 0000000001", {turn, move_count, illegal_flag, game_over, winner, move_ready}); end
    step();
    n_vec++; if (move_count !== 4'd0) begin n_err++; $display("FAIL ng_no_commit: got %0d want 0", move_count); end
`ifdef WIN_SCORE_EN
    n_vec++; if ({x_score, o_score} !== 8'h10) begin n_err++; $display("FAIL ng_score_kept: got %h want 10", {x_score, o_score}); end
`endif
    move_valid = 1'b1; move_pos = 4'd3;
    step();
    move_valid = 1'b0;
    n_vec++; if (X_en !== 9'h008) begin n_err++; $display("FAIL ng_first_player: got %h want %h", X_en, 9'h008); end
    step(); step();
    occ[3] = 1'b1;
  endtask

  task automatic test_back_to_back();
    new_game = 1'b1; move_valid = 1'b1; move_pos = 4'd2;
    step();
    new_game = 1'b0; move_valid = 1'b0; occ = '0;
    n_vec++; if ({X_en, O_en, move_ready} !== {9'h0, 9'h0, 1'b1}) begin n_err++; $display("FAIL b2b_drop: got %h want %h", {X_en, O_en, move_ready}, {9'h0, 9'h0, 1'b1}); end
    step();
    n_vec++; if ({board_v, move_count} !== 22'h0) begin n_err++; $display("FAIL b2b_idle: got %h want 0", {board_v, move_count}); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
`ifdef WIN_SCORE_EN
    n_vec++; if ({x_score, o_score} !== 8'h00) begin n_err++; $display("FAIL b2b_score_rst: got %h want 00", {x_score, o_score}); end
`endif
    n_vec++; if ({move_ready, turn} !== 2'b10) begin n_err++; $display("FAIL b2b_rst_ready: got %b want 10", {move_ready, turn}); end
  endtask

  initial begin
    test_reset();
    test_x_move();
    test_illegal_occupied();
    test_bad_code();
    test_win();
    test_draw();
    test_new_game_mid_check();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/board_turn_controller.md
Name: board_turn_controller

Overview:
- Sequential board-state and turn controller for the tic-tac-toe datapath.
- Accepts player move requests and drives the one-hot `X_en`/`O_en` enables plus the nine 2-bit cell registers `pos1..pos9` into the downstream illegal-move checker.
- Consumes the checker's `illegal_move` result, commits legal moves, alternates turns and detects win or draw.

Parameters:
- FIRST_PLAYER, 0, player that moves first after reset or new game (0 = X, 1 = O).
- SCORE_W, 4, width of the win counters; used only with WIN_SCORE_EN.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- new_game  input  1  synchronous board clear; highest priority after reset.
- move_valid  input  1  move request strobe.
- move_pos  input  4  requested cell, 0..8 maps to pos1..pos9; 9..15 are invalid codes.
- illegal_move  input  1  combinational result returned by the checker.
- move_ready  output  1  controller can accept a move this cycle.
- pos1..pos9  output  2 each  cell state: 00 empty, 01 X, 10 O; 11 never driven.
- X_en  output  9  one-hot X move enable, bit k = cell k.
- O_en  output  9  one-hot O move enable.
- turn  output  1  player to move (0 = X, 1 = O).
- illegal_flag  output  1  one-cycle pulse on a rejected move.
- move_count  output  4  committed moves, 0..9.
- game_over  output  1  game finished.
- winner  output  2  00 none, 01 X, 10 O, 11 draw.

Behaviour:
- Reset (`rst_n` = 0 at a clk edge): state WAIT.
  - All `pos` = 00; `X_en` = `O_en` = 0; `turn` = FIRST_PLAYER.
  - `move_count` = 0; `illegal_flag` = 0; `game_over` = 0; `winner` = 00.
  - `move_ready` = 1 from the first cycle after reset.
- `new_game` = 1 (with `rst_n` = 1): identical clear next cycle, from any state, including mid-CHECK.
  - Win counters are preserved.
- States: WAIT, CHECK, EVAL, OVER. All outputs are registered.
- WAIT:
  - `move_ready` = 1.
  - On `move_valid` with `move_pos` ≤ 8: latch the cell; next cycle assert exactly one bit (X_en if `turn` = 0, else O_en); go to CHECK.
  - On `move_valid` with `move_pos` ≥ 9: `illegal_flag` pulses for 1 cycle; stay in WAIT; nothing else changes.
- CHECK (exactly 1 cycle):
  - `move_ready` = 0; the enable is held for the whole cycle; `illegal_move` is sampled at the end of the cycle.
  - If `illegal_move` = 0: write the cell (01 or 10), toggle `turn`, increment `move_count`, clear the enables, go to EVAL.
  - If `illegal_move` = 1: board, `turn` and `move_count` are unchanged; `illegal_flag` pulses for 1 cycle; clear the enables; go to WAIT.
- EVAL (1 cycle, `move_ready` = 0): check the 8 lines (3 rows, 3 columns, 2 diagonals) against the just-moved player's code.
  - Line complete: go to OVER with `winner` = that player.
  - Otherwise, if `move_count` = 9: go to OVER with `winner` = 11.
  - Otherwise: go to WAIT.
- OVER: `game_over` = 1, `move_ready` = 0, `move_valid` ignored; exit only via `new_game` or reset.
- Latency: a legal move accepted in cycle N has its cell updated and `turn` toggled at edge N+2; `move_ready` returns at N+3 (or OVER is entered at N+3).
- `move_valid` while `move_ready` = 0 is dropped; no queueing.
- Simultaneous `new_game` and `move_valid`: `new_game` wins; the move is dropped.
- `move_count` never exceeds 9.

Optional Feature:
- Macro: WIN_SCORE_EN.
- Defined:
  - Adds outputs `x_score` and `o_score` [SCORE_W-1:0].
  - The winner's counter increments by 1 on entry to OVER; a draw increments neither.
  - Counters saturate at 2^SCORE_W−1.
  - Cleared only by `rst_n`, not by `new_game`.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then X move at cell 4 (tie `illegal_move` to a reference model) → at CHECK `X_en` = 9'h010; after commit `pos5` = 01, `turn` = 1, `move_count` = 1, `move_ready` back 3 cycles after acceptance.
- O move at the occupied cell 4 (model returns `illegal_move` = 1) → `illegal_flag` 1-cycle pulse; `pos5` stays 01, `turn` stays 1, `move_count` stays 1.
- `move_pos` = 12 in WAIT → `illegal_flag` pulse the next cycle; no enable asserted; no state change.
- X plays 0, 4, 8 with O at 1, 2 → after X's third move `winner` = 01, `game_over` = 1; further `move_valid` ignored; `x_score` = 1 if WIN_SCORE_EN.
- Fill the board with sequence 0, 1, 2, 4, 3, 5, 7, 6, 8 → `move_count` = 9, `winner` = 11, `game_over` = 1.
- Assert `new_game` during CHECK → next cycle all `pos` = 00, enables = 0, `turn` = FIRST_PLAYER, state WAIT; with WIN_SCORE_EN, scores retained; `rst_n` low clears the scores to 0.
